// File: rtl/trig_frame_tx_pkg.sv
// Shared types and widths for the trigger frame transmitter.
// The PARITY_EN build adds the parity state to the state enum.
package trig_frame_tx_pkg;

  localparam int DATA_BITS = 8;
  localparam logic [3:0] HDR_DEFAULT = 4'hA;
  localparam int BIT_IDX_W = 3;
  localparam int GAP_W = 8;
  localparam int STOP_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef PARITY_EN
    ST_PAR,
`endif
    ST_STOP,
    ST_GAP
  } state_e;

  function automatic logic [7:0] frame_byte(input logic [3:0] hdr, input logic [3:0] sw);
    return {hdr, sw};
  endfunction

endpackage

// File: rtl/trig_frame_tx_rise_detect.sv
// Registered previous-value edge detector; rise is high for the cycle the input
// is seen high after having been low.
module trig_frame_tx_rise_detect (
  input  logic sysclk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic din_q;
  logic din_d;

  always_comb din_d = din;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) din_q <= 1'b0;
    else        din_q <= din_d;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/trig_frame_tx.sv
// Serialises {HDR, sw_latch} as a UART-style frame on each trigger rise, with
// optional auto-repeat after an idle gap. Define PARITY_EN to add an even parity bit.
module trig_frame_tx
  import trig_frame_tx_pkg::*;
#(
  parameter logic [3:0] HDR       = HDR_DEFAULT,
  parameter int         STOP_BITS = 1,
  parameter int         GAP_TICKS = 16,
  parameter int         CNT_W     = 8
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             baud_tick,
  input  logic             trig,
  input  logic             auto_mode,
  input  logic [3:0]       sw_latch,
  output logic             tx,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [STOP_W-1:0]    STOP_LOAD = STOP_W'(STOP_BITS - 1);
  localparam logic [GAP_W-1:0]     GAP_LOAD  = GAP_W'(GAP_TICKS - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(DATA_BITS - 1);

  logic rise;

  trig_frame_tx_rise_detect u_rise (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .din    (trig),
    .rise   (rise)
  );

  state_e               state_q, state_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pending_q, pending_d;
  logic [7:0]           shreg_q, shreg_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [STOP_W-1:0]    stop_q, stop_d;
  logic                 commit;
`ifdef PARITY_EN
  logic                 par_q, par_d;
`endif

  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    bit_idx_d    = bit_idx_q;
    gap_d        = gap_q;
    stop_d       = stop_q;
    commit       = 1'b0;
`ifdef PARITY_EN
    par_d        = par_q;
`endif
    if (baud_tick) begin
      case (state_q)
        ST_IDLE: if (pending_q) commit = 1'b1;
        ST_START: begin
          tx_d      = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
        ST_DATA: begin
          if (bit_idx_q == LAST_BIT) begin
`ifdef PARITY_EN
            tx_d    = par_q;
            state_d = ST_PAR;
`else
            tx_d    = 1'b1;
            stop_d  = STOP_LOAD;
            state_d = ST_STOP;
`endif
          end else begin
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          end
        end
`ifdef PARITY_EN
        ST_PAR: begin
          tx_d    = 1'b1;
          stop_d  = STOP_LOAD;
          state_d = ST_STOP;
        end
`endif
        ST_STOP: begin
          if (stop_q == '0) begin
            frame_done_d = 1'b1;
            cnt_d        = cnt_q + CNT_W'(1);
            // A queued trigger takes priority over the auto gap: back-to-back frame.
            if (pending_q) begin
              commit = 1'b1;
            end else if (auto_mode) begin
              gap_d   = GAP_LOAD;
              state_d = ST_GAP;
            end else begin
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end else begin
            stop_d = stop_q - STOP_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_q == '0) begin
            if (auto_mode || pending_q) begin
              commit = 1'b1;
            end else begin
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (commit) begin
      state_d = ST_START;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
      shreg_d = frame_byte(HDR, sw_latch);
`ifdef PARITY_EN
      par_d   = ^frame_byte(HDR, sw_latch);
`endif
    end
    // Set wins over clear so a rise on the commit cycle is not lost.
    pending_d = (pending_q & ~commit) | rise;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      shreg_q      <= '0;
      bit_idx_q    <= '0;
      gap_q        <= '0;
      stop_q       <= '0;
`ifdef PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      shreg_q      <= shreg_d;
      bit_idx_q    <= bit_idx_d;
      gap_q        <= gap_d;
      stop_q       <= stop_d;
`ifdef PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = cnt_q;

endmodule
